// File: rtl/ham38_pkg.sv
// Shared constants and helpers for the 38-bit Hamming SEC decoder.
package ham38_pkg;

    localparam int unsigned CW_W          = 38;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned PAR_W         = 6;
    localparam int unsigned BLK_WORDS_DEF = 32;

    // Parity bits sit at the power-of-two Hamming positions 1,2,4,8,16,32.
    localparam logic [CW_W-1:0] PAR_MASK = 38'h00_8000_808B;

    // Strip the parity bits; remaining bits map to d0..d31 in ascending order.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        logic [4:0]        k;
        d = '0;
        k = '0;
        for (int unsigned j = 0; j < CW_W; j++) begin
            if (!PAR_MASK[j[5:0]]) begin
                d[k] = cw[j[5:0]];
                k    = k + 5'd1;
            end
        end
        return d;
    endfunction

    // Syndrome is the XOR of the Hamming positions of every set bit.
    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < CW_W; j++) begin
            if (cw[j[5:0]]) begin
                s = s ^ PAR_W'(j + 1);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ham38_syndrome.sv
// Combinational 6-bit syndrome of a 38-bit Hamming codeword.
module ham38_syndrome
    import ham38_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [PAR_W-1:0] o_syn
);

    // Pure function of the codeword; reusable by an encoder self-check.
    always_comb begin
        o_syn = calc_syndrome(i_cw);
    end

endmodule

// File: rtl/ham38_decoder.sv
// Two-stage streaming Hamming SEC decoder (38-bit codeword -> 32-bit data).
// Optional error counters are enabled with the macro HAM38_ERR_CNT_EN.
module ham38_decoder
    import ham38_pkg::*;
#(
    parameter int unsigned BLK_WORDS = BLK_WORDS_DEF
`ifdef HAM38_ERR_CNT_EN
    ,
    parameter int unsigned CNT_W     = 16
`endif
)
(
    input  logic              clk,
    input  logic              rst,
`ifdef HAM38_ERR_CNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_idx,
    output logic              out_last,
    output logic              out_corr,
    output logic              out_uncorr
);

    localparam int unsigned IDX_W = 5;

    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic [PAR_W-1:0]  r_s1_syn;
    logic [IDX_W-1:0]  r_idx;

    logic [PAR_W-1:0]  w_syn;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_hs;
    logic              w_corr;
    logic              w_uncorr;
    logic [CW_W-1:0]   w_flip;
    logic [DATA_W-1:0] w_data;

    ham38_syndrome u_syndrome (
        .i_cw  (in_cw),
        .o_syn (w_syn)
    );

    // Pipeline advance and handshake decode.
    always_comb begin
        w_s2_adv = !out_valid || out_ready;
        w_s1_adv = !r_s1_valid || w_s2_adv;
        w_out_hs = out_valid && out_ready;
        in_ready = w_s1_adv;
        out_idx  = r_idx;
        out_last = (r_idx == IDX_W'(BLK_WORDS - 1));
    end

    // Classify the syndrome and correct a single flipped bit.
    always_comb begin
        w_corr   = (r_s1_syn != '0) && (r_s1_syn <= PAR_W'(CW_W));
        w_uncorr = (r_s1_syn > PAR_W'(CW_W));
        w_flip   = '0;
        if (w_corr) begin
            w_flip = CW_W'(1) << (r_s1_syn - PAR_W'(1));
        end
        w_data   = extract_data(r_s1_cw ^ w_flip);
    end

    // Stage 1: capture codeword and its syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw  <= in_cw;
                r_s1_syn <= w_syn;
            end
        end
    end

    // Stage 2: register corrected data and flags; hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data   <= w_data;
                out_corr   <= w_corr;
                out_uncorr <= w_uncorr;
            end
        end
    end

    // Word index within the block, advancing on each output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_out_hs) begin
            if (r_idx == IDX_W'(BLK_WORDS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

`ifdef HAM38_ERR_CNT_EN
    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (w_out_hs && out_corr && !(&corr_cnt)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (w_out_hs && out_uncorr && !(&uncorr_cnt)) begin
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ham38_decoder.sv
// Scoreboard bench for ham38_decoder: driver pushes expectations, monitor pops on output handshakes.
module tb_ham38_decoder;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        corr;
        logic        uncorr;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        out_corr;
    logic        out_uncorr;
`ifdef HAM38_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_last   = 0;
    int   ready_mode = 0;
    int   exp_idx  = 0;
    exp_t q[$];

    ham38_decoder dut (
        .clk        (clk),
        .rst        (rst),
`ifdef HAM38_ERR_CNT_EN
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent encoder used to build clean codewords for the stream test.
    function automatic logic [37:0] enc(input logic [31:0] d);
        logic [37:0] cw;
        logic [5:0]  s;
        int          k;
        cw = '0;
        s  = '0;
        k  = 0;
        for (int j = 0; j < 38; j++) begin
            if (!(j == 0 || j == 1 || j == 3 || j == 7 || j == 15 || j == 31)) begin
                cw[j] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 38; j++) if (cw[j]) s = s ^ 6'(j + 1);
        for (int i = 0; i < 6; i++) if (s[i]) cw[(1 << i) - 1] = 1'b1;
        return cw;
    endfunction

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
    initial begin
        int pi;
        pi = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ((pi % 4) == 0) || ((pi % 4) == 3);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            pi++;
        end
    end

    // Monitor: compare each output handshake against the queue and check stall stability.
    initial begin
        logic        stall_prev;
        logic [31:0] s_data;
        logic [4:0]  s_idx;
        logic        s_corr;
        logic        s_uncorr;
        exp_t        e;
        stall_prev = 1'b0;
        s_data = '0; s_idx = '0; s_corr = 1'b0; s_uncorr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_hold", 64'({out_valid, out_data, out_idx, out_corr, out_uncorr}),
                        64'({1'b1, s_data, s_idx, s_corr, s_uncorr}));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 64'(out_data), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = q.pop_front();
                        chk("out_data",   64'(out_data),   64'(e.data));
                        chk("out_idx",    64'(out_idx),    64'(e.idx));
                        chk("out_corr",   64'(out_corr),   64'(e.corr));
                        chk("out_uncorr", 64'(out_uncorr), 64'(e.uncorr));
                        chk("out_last",   64'(out_last),   64'(e.last));
                        if (out_last) n_last++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                s_data = out_data; s_idx = out_idx; s_corr = out_corr; s_uncorr = out_uncorr;
            end
        end
    end

    task automatic send(input logic [37:0] cw, input logic [31:0] d, input logic c, input logic u);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_cw    = cw;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", 64'(0), 64'(1));
        end else begin
            e.data   = d;
            e.idx    = 5'(exp_idx);
            e.corr   = c;
            e.uncorr = u;
            e.last   = (exp_idx == 31);
            exp_idx  = (exp_idx == 31) ? 0 : exp_idx + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 64'(q.size()), 64'(0));
    endtask

    initial begin
        int base_last;
        logic [31:0] d;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_cw    = '0;
`ifdef HAM38_ERR_CNT_EN
        cnt_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  64'(out_valid),  64'(0));
        chk("rst_in_ready",   64'(in_ready),   64'(1));
        chk("rst_out_data",   64'(out_data),   64'(0));
        chk("rst_out_idx",    64'(out_idx),    64'(0));
        chk("rst_out_last",   64'(out_last),   64'(0));
        chk("rst_out_corr",   64'(out_corr),   64'(0));
        chk("rst_out_uncorr", 64'(out_uncorr), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed codewords with hand-derived results.
        send(38'h7,                      32'h1,         1'b0, 1'b0); // clean
        send(38'h7 ^ 38'h20,             32'h1,         1'b1, 1'b0); // syndrome 6
        send(38'h0 ^ 38'h8000,           32'h0,         1'b1, 1'b0); // parity error, syndrome 16
        send(38'h8000_0040,              32'h8,         1'b0, 1'b1); // syndrome 39
        send(38'h20_0000_0000,           32'h0,         1'b1, 1'b0); // syndrome 38, d31 flipped back
        send(38'h0_C000_0000,            32'h0200_0000, 1'b0, 1'b1); // syndrome 63
        send(38'h7 ^ 38'hC,              32'h8,         1'b1, 1'b0); // double error miscorrected
        wait_drain();

        // Reset with two words in flight under backpressure.
        ready_mode = 2;
        @(posedge clk);
        #2;
        send(enc(32'h1111), 32'h1111, 1'b0, 1'b0);
        send(enc(32'h2222), 32'h2222, 1'b0, 1'b0);
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_in_ready",  64'(in_ready),  64'(0));
        rst = 1'b1;
        q.delete();
        exp_idx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 64'(out_valid), 64'(0));
        chk("postrst_out_idx",   64'(out_idx),   64'(0));
        chk("postrst_in_ready",  64'(in_ready),  64'(1));
`ifdef HAM38_ERR_CNT_EN
        chk("postrst_corr_cnt",   64'(corr_cnt),   64'(0));
        chk("postrst_uncorr_cnt", 64'(uncorr_cnt), 64'(0));
`endif
        ready_mode = 0;
        repeat (6) @(posedge clk);
        #2;

        // Two full blocks of clean words under toggling backpressure.
        base_last  = n_last;
        ready_mode = 1;
        for (int k = 0; k < 64; k++) begin
            d = 32'h5A00_0000 ^ (32'(k) * 32'h0101_0103);
            send(enc(d), d, 1'b0, 1'b0);
        end
        wait_drain();
        ready_mode = 0;
        chk("last_count", 64'(n_last - base_last), 64'(2));
        @(negedge clk);
        chk("final_idx", 64'(out_idx), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
